// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for the MIPS execute stage.
//   Operations: MULT, MULTU (radix-2 shift-add), DIV, DIVU (restoring
//   shift-subtract), MTHI, MTLO (direct register writes). Signed operations
//   work on magnitudes and apply a two's-complement fix-up at the end.
//
//   Optional build macro: MDU_FAST_MUL_EN
//     defined   -> MULT/MULTU use a combinational multiplier and skip RUN
//     undefined -> all multiplies iterate for DATA_WIDTH cycles
//
// Ports:
//   clock      rising-edge clock
//   resetN     asynchronous active-low reset
//   start      operation request, sampled on every rising edge
//   op         0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=ignored
//   a, b       operands (a is also the MTHI/MTLO source)
//   busy       high while a multiply/divide is in progress
//   done       one-cycle pulse when hi/lo hold a new result
//   hi, lo     result registers (product halves / remainder, quotient)
//   divByZero  sticky flag from the most recent divide
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 6
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  divByZero
);

   localparam int W = DATA_WIDTH;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [2*W-1:0]         acc_q, acc_d;
   logic [W-1:0]           opnd_q, opnd_d;       // multiplicand or divisor magnitude
   logic                   is_div_q, is_div_d;
   logic                   lo_neg_q, lo_neg_d;   // negate product / quotient
   logic                   hi_neg_q, hi_neg_d;   // negate remainder
   logic                   dz_q, dz_d;
   logic [W-1:0]           hi_q, hi_d;
   logic [W-1:0]           lo_q, lo_d;
   logic                   done_q, done_d;
   logic                   dbz_q, dbz_d;
   // MTHI/MTLO are committed one edge after acceptance so that the write
   // and its done pulse land in the same cycle as for the other operations
   logic                   mt_hi_q, mt_hi_d;
   logic                   mt_lo_q, mt_lo_d;
   logic [W-1:0]           mt_data_q, mt_data_d;

   // Start-time operand conditioning
   logic         op_is_mul, op_is_div, op_signed, a_neg, b_neg, b_zero;
   logic [W-1:0] a_mag, b_mag;

   // Iteration datapath
   logic [W:0]     mul_sum, div_shift, div_diff;
   logic           div_ok;
   logic [2*W-1:0] mul_next, div_next, prod_fix;
   logic [W-1:0]   q_fix, r_fix;
`ifdef MDU_FAST_MUL_EN
   logic [2*W-1:0] fast_prod;
`endif

   always_comb begin
      op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
      op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      a_neg     = op_signed && a[W-1];
      b_neg     = op_signed && b[W-1];
      b_zero    = (b == '0);
      b_mag     = b_neg ? -b : b;
      // A zero divisor passes the raw dividend through so the iteration
      // leaves it untouched in the remainder (hi = a, lo = all ones).
      if (op_is_div && b_zero) a_mag = a;
      else                     a_mag = a_neg ? -a : a;
   end

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[W-1:1]};
      div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ok    = ~div_diff[W];
      div_next  = {(div_ok ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ok};
      prod_fix  = lo_neg_q ? -acc_q : acc_q;
      q_fix     = lo_neg_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
      r_fix     = hi_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
   end

`ifdef MDU_FAST_MUL_EN
   assign fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

   // Next-state and register updates
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      lo_neg_d  = lo_neg_q;
      hi_neg_d  = hi_neg_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;
      mt_hi_d   = 1'b0;
      mt_lo_d   = 1'b0;
      mt_data_d = mt_data_q;

      if (mt_hi_q) hi_d = mt_data_q;
      if (mt_lo_q) lo_d = mt_data_q;
      if (mt_hi_q || mt_lo_q) done_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (start && (op_is_mul || op_is_div)) begin
               cnt_d    = '0;
               is_div_d = op_is_div;
               dz_d     = op_is_div && b_zero;
               lo_neg_d = (a_neg ^ b_neg) && !(op_is_div && b_zero);
               hi_neg_d = op_is_div ? (a_neg && !b_zero) : (a_neg ^ b_neg);
               opnd_d   = op_is_mul ? a_mag : b_mag;
               acc_d    = {{W{1'b0}}, (op_is_mul ? b_mag : a_mag)};
               state_d  = RUN;
`ifdef MDU_FAST_MUL_EN
               if (op_is_mul) begin
                  acc_d   = fast_prod;
                  state_d = FIX;
               end
`endif
            end else if (start && (op == OP_MTHI)) begin
               mt_hi_d   = 1'b1;
               mt_data_d = a;
            end else if (start && (op == OP_MTLO)) begin
               mt_lo_d   = 1'b1;
               mt_data_d = a;
            end
         end
         RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + COUNT_WIDTH'(1);
            if (cnt_q == COUNT_WIDTH'(W - 1)) state_d = FIX;
         end
         FIX: begin
            if (is_div_q) begin
               hi_d  = r_fix;
               lo_d  = q_fix;
               dbz_d = dz_q;
            end else begin
               hi_d = prod_fix[2*W-1:W];
               lo_d = prod_fix[W-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         lo_neg_q  <= 1'b0;
         hi_neg_q  <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         mt_hi_q   <= 1'b0;
         mt_lo_q   <= 1'b0;
         mt_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         lo_neg_q  <= lo_neg_d;
         hi_neg_q  <= hi_neg_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
         mt_hi_q   <= mt_hi_d;
         mt_lo_q   <= mt_lo_d;
         mt_data_q <= mt_data_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign divByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed vectors with hand-computed results for mult_div_unit (32-bit),
//   plus sequences for ignored starts, reserved ops and mid-operation reset.
//   Expected multiply latency follows MDU_FAST_MUL_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = W + 2;
`endif
   localparam int DIV_LAT = W + 2;

   logic         clock = 1'b0;
   logic         resetN;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, divByZero;
   logic [W-1:0] hi, lo;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mult_div_unit #(.DATA_WIDTH(W), .COUNT_WIDTH(6)) dut (
      .clock     (clock),
      .resetN    (resetN),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .divByZero (divByZero)
   );

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } vec_t;

   vec_t vecs[15];

   // Values captured in the cycle done was seen
   int           got_lat, got_busy;
   logic [W-1:0] got_hi, got_lo;
   logic         got_dbz;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op and wait (bounded) for done; sampled #1 after each edge.
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clock);
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clock); #1;
      start = 1'b0;
      got_lat  = 1;
      got_busy = 0;
      while (!done && got_lat < 100) begin
         if (busy) got_busy++;
         @(posedge clock); #1;
         got_lat++;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL timeout: no done within %0d cycles (op %0d)", got_lat, o);
      end
      chk("busy_at_done", busy, 0);
      got_hi  = hi;
      got_lo  = lo;
      got_dbz = divByZero;
      @(posedge clock); #1;
      chk("done_one_cycle", done, 0);
   endtask

   function automatic int exp_lat(input logic [2:0] o);
      if (o <= 3'd1) return MUL_LAT;
      if (o <= 3'd3) return DIV_LAT;
      return 2;
   endfunction

   initial begin
      int lat;
      logic seen;

      vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
      vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
      vecs[4]  = '{3'd0, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b1};
      vecs[5]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
      vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[8]  = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      vecs[9]  = '{3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
      vecs[10] = '{3'd5, 32'h00005678, 32'h00000000, 32'h00001234, 32'h00005678, 1'b1};
      vecs[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1};
      vecs[12] = '{3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b1};
      vecs[13] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
      vecs[14] = '{3'd2, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};

      resetN = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", divByZero, 0);
      @(negedge clock);
      resetN = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 15; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b);
         $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, got_hi, got_lo, got_dbz, got_lat);
         chk($sformatf("v%0d_hi", i), got_hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), got_lo, vecs[i].lo);
         chk($sformatf("v%0d_dbz", i), got_dbz, vecs[i].dbz);
         chk($sformatf("v%0d_lat", i), got_lat, exp_lat(vecs[i].op));
         chk($sformatf("v%0d_busy", i), got_busy,
             (vecs[i].op >= 3'd4) ? 0 : exp_lat(vecs[i].op) - 1);
      end

      // Reserved op: no done, no busy, registers unchanged
      @(negedge clock);
      start = 1'b1; op = 3'd6; a = 32'hAAAA5555; b = 32'h3;
      @(posedge clock); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) seen = 1'b1;
         @(posedge clock); #1;
      end
      $display("reserved op 6 -> seen=%0d hi=%h lo=%h", seen, hi, lo);
      chk("rsv_quiet", seen, 0);
      chk("rsv_hi", hi, 32'h00000002);
      chk("rsv_lo", lo, 32'hFFFFFFF2);

      // DIV with an MTLO pulse at k+5 that must be ignored
      @(negedge clock);
      start = 1'b1; op = 3'd2; a = 32'hFFFFFFF9; b = 32'h2;
      @(posedge clock); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         if (lat == 5) begin start = 1'b1; op = 3'd5; a = 32'hDEADBEEF; end
         else start = 1'b0;
         @(posedge clock); #1;
         lat++;
      end
      start = 1'b0;
      $display("div with mtlo pulse -> hi=%h lo=%h lat=%0d", hi, lo, lat);
      chk("ovl_lat", lat, DIV_LAT);
      chk("ovl_lo", lo, 32'hFFFFFFFD);
      chk("ovl_hi", hi, 32'hFFFFFFFF);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clock); #1;
         if (done) seen = 1'b1;
      end
      chk("ovl_no_queue", seen, 0);
      chk("ovl_lo_hold", lo, 32'hFFFFFFFD);

      // Set divByZero, then reset in the middle of a divide
      do_op(3'd3, 32'h7, 32'h0);
      chk("pre_rst_dbz", got_dbz, 1);
      @(negedge clock);
      start = 1'b1; op = 3'd2; a = 32'h64; b = 32'hFFFFFFF9;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #2;
      resetN = 1'b0;
      #1;
      $display("mid-op reset -> hi=%h lo=%h busy=%0d done=%0d dbz=%0d", hi, lo, busy, done, divByZero);
      chk("mrst_hi", hi, 0);
      chk("mrst_lo", lo, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_dbz", divByZero, 0);
      @(negedge clock);
      resetN = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (done || busy) seen = 1'b1;
      end
      chk("mrst_quiet", seen, 0);

      // Recovery after reset
      do_op(3'd1, 32'h3, 32'h5);
      $display("post-reset multu 3*5 -> hi=%h lo=%h lat=%0d", got_hi, got_lo, got_lat);
      chk("rec_lo", got_lo, 32'hF);
      chk("rec_hi", got_hi, 0);
      chk("rec_lat", got_lat, MUL_LAT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
